// File: rtl/alu_4bit_reg.sv
// Registered ALU: add, subtract, AND, OR on two unsigned operands.
// Result and carry/borrow are registered; they become valid one cycle after the operands.
module alu_4bit_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;

  // One extra bit on both arithmetic paths. For subtraction that extra bit
  // is set exactly when A < B, so it gives the borrow.
  assign sum_ext  = {1'b0, A} + {1'b0, B};
  assign diff_ext = {1'b0, A} - {1'b0, B};

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    case (op_t'(sel))
      OP_ADD: begin
        next_result = sum_ext[WIDTH-1:0];
        next_carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        next_result = diff_ext[WIDTH-1:0];
        next_carry  = diff_ext[WIDTH];
      end
      OP_AND: next_result = A & B;
      OP_OR:  next_result = A | B;
      default: begin
        next_result = '0;
        next_carry  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      result    <= next_result;
      carry_out <= next_carry;
    end
  end

endmodule

// File: tb/tb_alu_4bit_reg.sv
// Bench for alu_4bit_reg. A vector table covers reset, opcode steps and wrap corners.
// Random streams with injected resets and a shuffled exhaustive sweep are checked against an arithmetic model.
module tb_alu_4bit_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   sel;
  logic [W-1:0] result;
  logic         carry_out;

  int tests_run;
  int tests_failed;
  logic [W:0] exp_q[$];

  alu_4bit_reg #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .A(a),
    .B(b),
    .sel(sel),
    .result(result),
    .carry_out(carry_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {carry, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input logic r, input int ai, input int bi, input int op);
    int res;
    int c;
    res = 0;
    c   = 0;
    if (r) return '0;
    case (op)
      0: begin
        res = (ai + bi) % 16;
        c   = (ai + bi >= 16) ? 1 : 0;
      end
      1: begin
        res = (ai - bi + 16) % 16;
        c   = (ai < bi) ? 1 : 0;
      end
      2: res = ai & bi;
      default: res = ai | bi;
    endcase
    return {c[0], res[W-1:0]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got carry=%b result=%b, required carry=%b result=%b",
               name, act[W], act[W-1:0], exp[W], exp[W-1:0]);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge and are captured on the next rising edge.
  // Outputs are compared 1 time unit after that rising edge.
  task automatic drive_step(input logic r, input logic [W-1:0] ai, input logic [W-1:0] bi,
                            input logic [1:0] op, input string name);
    logic [W:0] exp;
    @(negedge clk);
    rst = r;
    a   = ai;
    b   = bi;
    sel = op;
    exp_q.push_back(model(r, int'(ai), int'(bi), int'(op)));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check(name, {carry_out, result}, exp);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         r;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [1:0]   vs;
    logic [W-1:0] er;
    logic         ec;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [W:0] prev;
    int codes[1024];
    int j;
    int tmp;
    string nm;

    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b1;
    a   = '0;
    b   = '0;
    sel = 2'b00;
    prev = '0;

    vecs[0]  = '{1'b1, 4'h3, 4'h1, 2'b00, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 4'h3, 4'h1, 2'b00, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'h3, 4'h1, 2'b00, 4'h4, 1'b0};
    vecs[3]  = '{1'b0, 4'h3, 4'h1, 2'b01, 4'h2, 1'b0};
    vecs[4]  = '{1'b0, 4'h3, 4'h1, 2'b10, 4'h1, 1'b0};
    vecs[5]  = '{1'b0, 4'h3, 4'h1, 2'b11, 4'h3, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 4'h1, 2'b00, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 4'h5, 4'h5, 2'b01, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'h0, 4'h1, 2'b01, 4'hF, 1'b1};
    vecs[9]  = '{1'b0, 4'hC, 4'hA, 2'b10, 4'h8, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 4'hF, 2'b00, 4'hE, 1'b1};
    vecs[11] = '{1'b0, 4'hC, 4'hA, 2'b11, 4'hE, 1'b0};
    vecs[12] = '{1'b1, 4'hF, 4'hF, 2'b00, 4'h0, 1'b0};
    vecs[13] = '{1'b0, 4'h7, 4'h9, 2'b01, 4'hE, 1'b1};

    // Each entry is applied for one cycle. The outputs must hold their old
    // value until the next rising edge, then show the value in the table.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = vecs[i].r;
      a   = vecs[i].va;
      b   = vecs[i].vb;
      sel = vecs[i].vs;
      #1;
      if (i > 0) begin
        nm = $sformatf("hold_vec%0d", i);
        check(nm, {carry_out, result}, prev);
      end
      @(posedge clk);
      #1;
      nm = $sformatf("vec%0d", i);
      check(nm, {carry_out, result}, {vecs[i].ec, vecs[i].er});
      prev = {vecs[i].ec, vecs[i].er};
    end

    // Random operations, with reset asserted on about one cycle in twelve.
    for (int i = 0; i < 300; i++) begin
      nm = $sformatf("rand%0d", i);
      drive_step(($urandom_range(0, 11) == 0), W'($urandom_range(0, 15)),
                 W'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), nm);
    end

    // Every A/B/sel combination, applied back-to-back in shuffled order.
    for (int i = 0; i < 1024; i++) codes[i] = i;
    for (int i = 1023; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = codes[i];
      codes[i] = codes[j];
      codes[j] = tmp;
    end
    for (int i = 0; i < 1024; i++) begin
      nm = $sformatf("sweep_a%0d_b%0d_s%0d", codes[i] & 15, (codes[i] >> 4) & 15, (codes[i] >> 8) & 3);
      drive_step(1'b0, W'(codes[i] & 15), W'((codes[i] >> 4) & 15), 2'((codes[i] >> 8) & 3), nm);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
